// File: rtl/updown_bcd_counter_ctrl.sv
// Two-digit decimal up/down counter with run/pause and direction buttons.
// Produces four 4-bit display codes for the 7-segment value decoders:
//   val_hex0 ones digit, val_hex1 tens digit (blank when zero),
//   val_hex2 direction arrow, val_hex3 pause indicator.
// All display codes are derived from registered state only, so button
// activity never reaches the outputs without passing through a flop.

module updown_bcd_counter_ctrl #(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned MAX_COUNT = 99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_btn,
   input  logic       dir_btn,
   output logic [3:0] val_hex0,
   output logic [3:0] val_hex1,
   output logic [3:0] val_hex2,
   output logic [3:0] val_hex3,
   output logic       step
);

   // Prescaler width; a TICK_DIV of 2 still needs one bit.
   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   // Upper limit split into its decimal digits.
   localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

   // Display codes understood by the value decoders.
   localparam logic [3:0] CODE_UP    = 4'd10;
   localparam logic [3:0] CODE_DOWN  = 4'd11;
   localparam logic [3:0] CODE_BLANK = 4'd15;
   localparam logic [3:0] CODE_ZERO  = 4'd0;

   typedef enum logic [1:0] {
      StPausedUp,
      StPausedDown,
      StRunUp,
      StRunDown
   } state_t;

   state_t        state_q, state_d;
   logic          run_btn_q, dir_btn_q;
   logic          run_rise, dir_rise;
   logic          run_cur, up_cur;
   logic          run_nxt, up_nxt;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic          step_q;
   logic          at_max, at_zero;

   // Button history for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_btn_q <= 1'b0;
         dir_btn_q <= 1'b0;
      end else begin
         run_btn_q <= run_btn;
         dir_btn_q <= dir_btn;
      end
   end

   assign run_rise = run_btn & ~run_btn_q;
   assign dir_rise = dir_btn & ~dir_btn_q;

   // Decode the current state into run and direction flags.
   always_comb begin
      run_cur = 1'b0;
      up_cur  = 1'b1;
      unique case (state_q)
         StPausedUp: begin
            run_cur = 1'b0;
            up_cur  = 1'b1;
         end
         StPausedDown: begin
            run_cur = 1'b0;
            up_cur  = 1'b0;
         end
         StRunUp: begin
            run_cur = 1'b1;
            up_cur  = 1'b1;
         end
         StRunDown: begin
            run_cur = 1'b1;
            up_cur  = 1'b0;
         end
         default: begin
            run_cur = 1'b0;
            up_cur  = 1'b1;
         end
      endcase
   end

   // Next state: each edge toggles its own axis, both may apply at once.
   always_comb begin
      run_nxt = run_cur ^ run_rise;
      up_nxt  = up_cur ^ dir_rise;
      state_d = state_q;
      unique case ({run_nxt, up_nxt})
         2'b01:   state_d = StPausedUp;
         2'b00:   state_d = StPausedDown;
         2'b11:   state_d = StRunUp;
         2'b10:   state_d = StRunDown;
         default: state_d = StPausedUp;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StPausedUp;
      end else begin
         state_q <= state_d;
      end
   end

   // Prescaler advances only while the updated state is running, so a pause
   // edge freezes it and suppresses a coincident tick; resume keeps the count.
   always_comb begin
      tick    = 1'b0;
      presc_d = presc_q;
      if (run_nxt) begin
         if (presc_q == PRESC_LAST) begin
            tick    = 1'b1;
            presc_d = '0;
         end else begin
            presc_d = presc_q + PRESC_ONE;
         end
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
   assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

   // BCD count update on tick, using the direction after any coincident toggle.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (tick) begin
         if (up_nxt) begin
            if (at_max) begin
               tens_d = 4'd0;
               ones_d = 4'd0;
            end else if (ones_q == 4'd9) begin
               tens_d = tens_q + 4'd1;
               ones_d = 4'd0;
            end else begin
               ones_d = ones_q + 4'd1;
            end
         end else begin
            if (at_zero) begin
               tens_d = MAX_TENS;
               ones_d = MAX_ONES;
            end else if (ones_q == 4'd0) begin
               tens_d = tens_q - 4'd1;
               ones_d = 4'd9;
            end else begin
               ones_d = ones_q - 4'd1;
            end
         end
      end
   end

   // Count digits and the step pulse, which lands with the new count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_q <= 4'd0;
         ones_q <= 4'd0;
         step_q <= 1'b0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
         step_q <= tick;
      end
   end

   // Display codes from registered state only.
   always_comb begin
      val_hex0 = ones_q;
      val_hex1 = (tens_q == 4'd0) ? CODE_BLANK : tens_q;
      val_hex2 = up_cur ? CODE_UP : CODE_DOWN;
      val_hex3 = run_cur ? CODE_BLANK : CODE_ZERO;
      step     = step_q;
   end

endmodule

// File: tb/tb_updown_bcd_counter_ctrl.sv
// Bench for updown_bcd_counter_ctrl: two instances (fast 4-cycle / 0..99 and
// 2-cycle / 0..12) driven by the same buttons, compared each cycle against
// an integer-level model, plus literal checks of key scenarios.

module tb_updown_bcd_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run_btn;
   logic       dir_btn;
   logic [3:0] h0[2];
   logic [3:0] h1[2];
   logic [3:0] h2[2];
   logic [3:0] h3[2];
   logic       stp[2];

   int errors = 0;
   int checks = 0;

   // Model state: plain integers and flags per instance.
   bit m_run[2];
   bit m_up[2];
   bit m_step[2];
   int m_presc[2];
   int m_cnt[2];
   bit m_rbq;
   bit m_dbq;

   always #5 clk = ~clk;

   updown_bcd_counter_ctrl #(.TICK_DIV(4), .MAX_COUNT(99)) dut0 (
      .clk(clk), .rst_n(rst_n), .run_btn(run_btn), .dir_btn(dir_btn),
      .val_hex0(h0[0]), .val_hex1(h1[0]), .val_hex2(h2[0]), .val_hex3(h3[0]),
      .step(stp[0])
   );

   updown_bcd_counter_ctrl #(.TICK_DIV(2), .MAX_COUNT(12)) dut1 (
      .clk(clk), .rst_n(rst_n), .run_btn(run_btn), .dir_btn(dir_btn),
      .val_hex0(h0[1]), .val_hex1(h1[1]), .val_hex2(h2[1]), .val_hex3(h3[1]),
      .step(stp[1])
   );

   function automatic int td(input int i);
      return (i == 0) ? 4 : 2;
   endfunction

   function automatic int mx(input int i);
      return (i == 0) ? 99 : 12;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_run[i]   = 1'b0;
         m_up[i]    = 1'b1;
         m_step[i]  = 1'b0;
         m_presc[i] = 0;
         m_cnt[i]   = 0;
      end
      m_rbq = 1'b0;
      m_dbq = 1'b0;
   endtask

   task automatic model_clock();
      bit rr;
      bit dr;
      rr = run_btn && !m_rbq;
      dr = dir_btn && !m_dbq;
      for (int i = 0; i < 2; i++) begin
         if (rr) m_run[i] = !m_run[i];
         if (dr) m_up[i] = !m_up[i];
         m_step[i] = 1'b0;
         if (m_run[i]) begin
            if (m_presc[i] == td(i) - 1) begin
               m_presc[i] = 0;
               m_step[i]  = 1'b1;
            end else begin
               m_presc[i]++;
            end
         end
         if (m_step[i]) begin
            if (m_up[i]) m_cnt[i] = (m_cnt[i] == mx(i)) ? 0 : m_cnt[i] + 1;
            else         m_cnt[i] = (m_cnt[i] == 0) ? mx(i) : m_cnt[i] - 1;
         end
      end
      m_rbq = run_btn;
      m_dbq = dir_btn;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dut%0d hex0", i), h0[i], m_cnt[i] % 10);
         chk($sformatf("dut%0d hex1", i), h1[i], (m_cnt[i] / 10 == 0) ? 15 : m_cnt[i] / 10);
         chk($sformatf("dut%0d hex2", i), h2[i], m_up[i] ? 10 : 11);
         chk($sformatf("dut%0d hex3", i), h3[i], m_run[i] ? 15 : 0);
         chk($sformatf("dut%0d step", i), stp[i], m_step[i]);
      end
   endtask

   // One clock: advance the model at the edge, compare at the falling edge.
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_clock();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      run_btn = 1'b0;
      dir_btn = 1'b0;
      #1;
      model_reset();
      cycle();
      cycle();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic wait_steps(input int i, input int n, input int budget);
      int seen = 0;
      int c = 0;
      while (seen < n && c < budget) begin
         cycle();
         c++;
         if (stp[i]) seen++;
      end
      chk($sformatf("dut%0d steps within budget", i), seen, n);
   endtask

   task automatic pulse_run();
      run_btn = 1'b1;
      cycle();
      run_btn = 1'b0;
   endtask

   task automatic pulse_dir();
      dir_btn = 1'b1;
      cycle();
      dir_btn = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      rst_n   = 1'b0;
      run_btn = 1'b0;
      dir_btn = 1'b0;
      @(negedge clk);
      do_reset();

      // Reset values and idle while paused.
      for (int i = 0; i < 2; i++) begin
         chk("reset hex0", h0[i], 0);
         chk("reset hex1", h1[i], 15);
         chk("reset hex2", h2[i], 10);
         chk("reset hex3", h3[i], 0);
         chk("reset step", stp[i], 0);
      end
      s = 0;
      repeat (20) begin
         cycle();
         s += int'(stp[0]) + int'(stp[1]);
      end
      chk("no step while paused", s, 0);

      // Up wrap at 12 and down wrap on dut1.
      pulse_run();
      chk("run shows blank status", h3[1], 15);
      wait_steps(1, 12, 60);
      chk("dut1 at 12 tens", h1[1], 1);
      chk("dut1 at 12 ones", h0[1], 2);
      wait_steps(1, 1, 10);
      chk("up wrap ones", h0[1], 0);
      chk("up wrap tens blank", h1[1], 15);
      pulse_dir();
      chk("dir down arrow", h2[1], 11);
      wait_steps(1, 1, 10);
      chk("down wrap tens", h1[1], 1);
      chk("down wrap ones", h0[1], 2);
      wait_steps(1, 1, 10);
      chk("down to 11 ones", h0[1], 1);

      // Twelve steps on dut0.
      do_reset();
      pulse_run();
      wait_steps(0, 12, 100);
      chk("count 12 tens", h1[0], 1);
      chk("count 12 ones", h0[0], 2);
      chk("running status", h3[0], 15);

      // Asynchronous reset mid-run.
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async rst hex0", h0[0], 0);
      chk("async rst hex1", h1[0], 15);
      chk("async rst hex2", h2[0], 10);
      chk("async rst hex3", h3[0], 0);
      chk("async rst step", stp[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      s = 0;
      repeat (20) begin
         cycle();
         s += int'(stp[0]);
      end
      chk("no step after reset", s, 0);

      // Pause with prescaler at 2 of 4, hold, resume after the remainder.
      do_reset();
      pulse_run();
      cycle();
      pulse_run();
      chk("paused status", h3[0], 0);
      s = 0;
      repeat (50) begin
         cycle();
         s += int'(stp[0]);
      end
      chk("no step during pause", s, 0);
      chk("count frozen", h0[0], 0);
      pulse_run();
      chk("resume no step yet", stp[0], 0);
      cycle();
      chk("resume step after 2", stp[0], 1);
      chk("resume count 1", h0[0], 1);

      // Button held high toggles once.
      do_reset();
      run_btn = 1'b1;
      repeat (10) cycle();
      run_btn = 1'b0;
      cycle();
      chk("held run single toggle", h3[0], 15);

      // Run and dir edges together.
      do_reset();
      run_btn = 1'b1;
      dir_btn = 1'b1;
      cycle();
      run_btn = 1'b0;
      dir_btn = 1'b0;
      chk("both edges run", h3[0], 15);
      chk("both edges down", h2[0], 11);

      // Dir edge coincident with tick at 05.
      do_reset();
      pulse_run();
      wait_steps(0, 5, 40);
      chk("reached 05", h0[0], 5);
      repeat (3) cycle();
      pulse_dir();
      chk("coincident tick step", stp[0], 1);
      chk("coincident tick count 04", h0[0], 4);
      chk("coincident tick arrow", h2[0], 11);

      // Randomised button activity.
      do_reset();
      repeat (3000) begin
         if ($urandom_range(0, 19) == 0) run_btn = ~run_btn;
         if ($urandom_range(0, 29) == 0) dir_btn = ~dir_btn;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
